// File: rtl/pc_redirect_unit.sv
// IF-stage PC owner: applies ID-stage branch/jump redirects, flushes IF/ID, captures JAL links.
// Optional redirect counter output enabled by defining REDIRECT_STATS_EN.
module pc_redirect_unit #(
  parameter int                  WORD_LEN  = 32,
  parameter logic [WORD_LEN-1:0] RESET_PC  = '0,
  parameter int                  PC_STEP   = 4,
  parameter int                  IMM_SHIFT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                id_valid,
  input  logic                brCond,
  input  logic [1:0]          br_type,
  input  logic [WORD_LEN-1:0] id_pc,
  input  logic [15:0]         imm,
  input  logic [25:0]         jump_index,
  input  logic [WORD_LEN-1:0] reg1,
  input  logic                imem_ready,
  output logic [WORD_LEN-1:0] pc,
  output logic                fetch_valid,
  output logic                flush_ifid,
  output logic                redirect_pending,
  output logic                link_valid,
  output logic [WORD_LEN-1:0] link_addr
`ifdef REDIRECT_STATS_EN
  ,
  output logic [15:0]         redirect_count
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

  localparam logic [1:0] BR_BRANCH = 2'd0;
  localparam logic [1:0] BR_JUMP   = 2'd1;
  localparam logic [1:0] BR_JAL    = 2'd2;

  state_t              state, state_nxt;
  logic [WORD_LEN-1:0] pend_target, pend_target_nxt;
  logic [WORD_LEN-1:0] pc_nxt, link_addr_nxt;
  logic                fetch_valid_nxt, flush_nxt, pending_nxt, link_valid_nxt;
  logic [WORD_LEN-1:0] imm_ext, target;
  logic                take;
`ifdef REDIRECT_STATS_EN
  logic [15:0]         count_nxt;
`endif

  assign take    = id_valid & brCond & ~freeze;
  assign imm_ext = {{(WORD_LEN-16){imm[15]}}, imm};

  always_comb begin
    target = reg1;
    case (br_type)
      BR_BRANCH:      target = id_pc + (imm_ext << IMM_SHIFT);
      BR_JUMP, BR_JAL: target = {id_pc[WORD_LEN-1:28], jump_index, {IMM_SHIFT{1'b0}}};
      default:        target = reg1;
    endcase
  end

  // Every output is a register; this block only forms their next values.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    fetch_valid_nxt = fetch_valid;
    flush_nxt       = 1'b0;
    pending_nxt     = redirect_pending;
    pend_target_nxt = pend_target;
    link_valid_nxt  = 1'b0;
    link_addr_nxt   = link_addr;
`ifdef REDIRECT_STATS_EN
    count_nxt       = redirect_count;
`endif
    case (state)
      BOOT: begin
        state_nxt       = RUN;
        pc_nxt          = RESET_PC;
        fetch_valid_nxt = 1'b1;
      end
      RUN: begin
        if (take) begin
          flush_nxt = 1'b1;
          if (br_type == BR_JAL) begin
            link_valid_nxt = 1'b1;
            link_addr_nxt  = id_pc;
          end
`ifdef REDIRECT_STATS_EN
          if (redirect_count != 16'hFFFF) count_nxt = redirect_count + 16'd1;
`endif
          if (imem_ready) begin
            pc_nxt = target;
          end else begin
            pend_target_nxt = target;
            pending_nxt     = 1'b1;
            state_nxt       = PEND;
          end
        end else if (!freeze && imem_ready) begin
          pc_nxt = pc + WORD_LEN'(PC_STEP);
        end
      end
      PEND: begin
        // Flush stays up through the cycle the redirected PC first appears.
        flush_nxt = 1'b1;
        if (imem_ready) begin
          pc_nxt      = pend_target;
          pending_nxt = 1'b0;
          state_nxt   = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= BOOT;
      pc               <= RESET_PC;
      fetch_valid      <= 1'b0;
      flush_ifid       <= 1'b0;
      redirect_pending <= 1'b0;
      pend_target      <= '0;
      link_valid       <= 1'b0;
      link_addr        <= '0;
`ifdef REDIRECT_STATS_EN
      redirect_count   <= '0;
`endif
    end else begin
      state            <= state_nxt;
      pc               <= pc_nxt;
      fetch_valid      <= fetch_valid_nxt;
      flush_ifid       <= flush_nxt;
      redirect_pending <= pending_nxt;
      pend_target      <= pend_target_nxt;
      link_valid       <= link_valid_nxt;
      link_addr        <= link_addr_nxt;
`ifdef REDIRECT_STATS_EN
      redirect_count   <= count_nxt;
`endif
    end
  end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- IF-stage program-counter owner; directly downstream of the ID-stage branch condition checker.
- Consumes brCond plus branch type, immediate and register operands; computes the redirect target and updates the PC.
- Generates the IF/ID flush and captures the JAL link address for writeback.
- Holds a redirect pending when instruction memory is not ready, so no taken branch is ever lost.

Parameters:
- WORD_LEN, 32, datapath/PC width.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment.
- IMM_SHIFT, 2, left shift applied to the sign-extended branch immediate and to jump_index.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-low reset
- freeze  input  1  hazard-unit stall; holds PC and blocks ID redirect acceptance
- id_valid  input  1  ID stage holds a real (non-bubble) instruction
- brCond  input  1  branch/jump taken, from condition checker
- br_type  input  2  0=BRANCH (PC-relative), 1=JUMP, 2=JAL, 3=JR
- id_pc  input  WORD_LEN  PC+PC_STEP of the instruction in ID
- imm  input  16  branch immediate
- jump_index  input  26  J/JAL target field
- reg1  input  WORD_LEN  rs value for JR
- imem_ready  input  1  instruction memory accepts a fetch this cycle
- pc  output  WORD_LEN  current fetch address
- fetch_valid  output  1  pc is a valid fetch request
- flush_ifid  output  1  squash the IF/ID register
- redirect_pending  output  1  a taken redirect is latched, waiting on imem_ready
- link_valid  output  1  one-cycle pulse: write link_addr to $31
- link_addr  output  WORD_LEN  return address

Behaviour:
- Reset (rst=0 at a rising edge):
  - pc=RESET_PC; fetch_valid=0, flush_ifid=0, redirect_pending=0, link_valid=0, link_addr=0; state=BOOT.
  - Reset mid-PEND discards the pending target.
- States: BOOT, RUN, PEND.
- BOOT: one cycle; fetch_valid=0; then RUN with pc=RESET_PC, fetch_valid=1.
- Redirect acceptance: take = id_valid & brCond & !freeze. take is ignored in BOOT and PEND.
- Target computation, all in WORD_LEN bits with wrap-around modulo 2^WORD_LEN:
  - BRANCH: target = id_pc + (sext(imm) << IMM_SHIFT).
  - JUMP/JAL: target = {id_pc[WORD_LEN-1:28], jump_index, IMM_SHIFT zero bits}.
  - JR: target = reg1.
- RUN, priority order:
  1. take & imem_ready: next-cycle pc=target; flush_ifid=1 for exactly one cycle; stay RUN.
  2. take & !imem_ready: latch target; redirect_pending=1; flush_ifid=1 every cycle while pending; go PEND; pc unchanged.
  3. !freeze & imem_ready: pc += PC_STEP.
  4. Otherwise hold pc.
- PEND:
  - pc holds.
  - When imem_ready=1: pc=latched target; redirect_pending=0; flush_ifid stays 1 in that cycle, deasserts the next; go RUN.
  - freeze is ignored in PEND.
- Link capture: on the cycle take occurs with br_type=JAL (including the take that enters PEND), register link_addr=id_pc and pulse link_valid for one cycle. link_addr holds its value until the next JAL.
- All outputs are registered.
- Latency: take at cycle N gives the new pc visible at cycle N+1 (if ready).
- fetch_valid=1 in RUN and PEND.
- Simultaneous freeze=1 & brCond=1: take is suppressed; pc holds.

Optional Feature:
- Macro: REDIRECT_STATS_EN.
- Defined:
  - Adds output redirect_count [15:0], reset to 0.
  - Increments once per accepted take, including takes that enter PEND; saturates at 16'hFFFF.
- Undefined:
  - Port and counter absent.
  - All other behaviour identical.

Test Plan:
- Reset/boot: hold rst=0 3 cycles, release, imem_ready=1 -> pc=0 for the BOOT and first RUN cycles, fetch_valid 0 then 1, then pc=4, 8, 12; all other outputs 0.
- Taken BRANCH: id_pc=0x40, imm=0xFFFE, brCond=1, br_type=0 -> next pc=0x38, flush_ifid high exactly 1 cycle, link_valid=0.
- JAL: id_pc=0x1000_0010, jump_index=0x0000100 -> pc=0x1000_0400, link_addr=0x1000_0010, link_valid one-cycle pulse.
- Pending redirect: JR with reg1=0x200 while imem_ready=0 for 3 cycles -> redirect_pending=1 and flush_ifid=1 for 3 cycles, pc held; imem_ready=1 -> pc=0x200, pending cleared next cycle.
- Freeze priority: freeze=1 with brCond=1 for 2 cycles -> pc unchanged, no flush; freeze drops with brCond=1 -> redirect taken.
- Wrap and reset mid-PEND: BRANCH with id_pc=0xFFFF_FFF0, imm=0x0008 -> pc=0x0000_0010. Enter PEND, assert rst=0 -> pc=RESET_PC, redirect_pending=0; with REDIRECT_STATS_EN defined, redirect_count returns to 0.
